// File: rtl/uart_8n1_transmitter_if.sv
// Byte producer <-> UART 8N1 transmitter handshake.
//   send_data  : byte to transmit, captured when a write is accepted
//   send_write : write strobe, honoured only while send_ready=1
//   send_ready : transmitter holding register is empty
//   send_break : hold the line low (only with UART_8N1_TX_BREAK_EN)
// master = byte producer, slave = transmitter.
interface uart_8n1_transmitter_if;
  logic [7:0] send_data;
  logic       send_write;
  logic       send_ready;
`ifdef UART_8N1_TX_BREAK_EN
  logic       send_break;

  modport master (output send_data, output send_write, output send_break, input send_ready);
  modport slave  (input send_data, input send_write, input send_break, output send_ready);
`else
  modport master (output send_data, output send_write, input send_ready);
  modport slave  (input send_data, input send_write, output send_ready);
`endif
endinterface

// File: rtl/uart_8n1_transmitter.sv
// UART 8N1 transmitter on the 16x baud clock (one bit = 16 clk_baud_16x cycles).
// A 1-deep holding register sits in front of the shifter so frames can run
// back-to-back with no idle gap.
//
// Ports:
//   clk_baud_16x : 16x baud clock
//   reset        : synchronous, active-high
//   send_if      : slave side of uart_8n1_transmitter_if (data/write/ready[/break])
//   tx           : TX line, registered, idles high
//   tx_active    : a frame (start .. stop + gap) is on the line
//   send_done    : one-cycle pulse in the last cycle of each frame
//
// Parameter GAP_TICKS (0..255): extra idle-high cycles after every stop bit.
// Build option UART_8N1_TX_BREAK_EN: adds send_break; while it is high and the
// shifter is idle the line is held low and no new frame starts.
//
// state    | meaning
// ST_IDLE  | line idle (or in break), waiting for a held byte
// ST_LOAD  | byte moved into shifter, start bit goes out next edge
// ST_FRAME | start/data/stop bits, cnt_q = {bit index, tick}
// ST_GAP   | GAP_TICKS idle-high cycles after the stop bit
module uart_8n1_transmitter #(
  parameter int unsigned GAP_TICKS = 0
) (
  input  logic                         clk_baud_16x,
  input  logic                         reset,
  uart_8n1_transmitter_if.slave        send_if,
  output logic                         tx,
  output logic                         tx_active,
  output logic                         send_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FRAME, ST_GAP} state_t;

  // Last tick of the stop bit: bit index 9, tick 15.
  localparam logic [7:0] CNT_LAST = 8'h9F;
  localparam bit         HAS_GAP  = (GAP_TICKS != 0);
  localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

  state_t     state_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic [7:0] shift_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] gap_q;
  logic       tx_q;
  logic       tx_active_q;
  logic       send_done_q;
  logic       accept;
  logic       brk;
  logic       frame_end;

`ifdef UART_8N1_TX_BREAK_EN
  assign brk = send_if.send_break;
`else
  assign brk = 1'b0;
`endif

  function automatic logic bit_val(input logic [3:0] idx, input logic [7:0] d);
    logic [3:0] n;
    n = idx - 4'd1;
    if (idx == 4'd0)
      return 1'b0;
    else if (idx <= 4'd8)
      return d[n[2:0]];
    else
      return 1'b1;
  endfunction

  assign accept = send_if.send_write && !hold_full_q;
  assign cnt_d  = cnt_q + 8'd1;

  // Final cycle of the frame: end of stop bit without gap, or end of gap.
  assign frame_end = ((state_q == ST_FRAME) && (cnt_q == CNT_LAST) && !HAS_GAP) ||
                     ((state_q == ST_GAP) && (gap_q == 8'd0));

  always_ff @(posedge clk_baud_16x) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      shift_q     <= 8'd0;
      cnt_q       <= 8'd0;
      gap_q       <= 8'd0;
      tx_q        <= 1'b1;
      tx_active_q <= 1'b0;
      send_done_q <= 1'b0;
    end else begin
      send_done_q <= 1'b0;

      // An accept only happens with holding empty, and holding is only freed
      // when full, so these two writes of hold_full_q never collide.
      if (accept) begin
        hold_q      <= send_if.send_data;
        hold_full_q <= 1'b1;
      end

      if (frame_end) begin
        if (hold_full_q && !brk) begin
          // Chain straight into the next start bit.
          shift_q     <= hold_q;
          hold_full_q <= 1'b0;
          state_q     <= ST_FRAME;
          cnt_q       <= 8'd0;
          tx_q        <= 1'b0;
        end else begin
          state_q     <= ST_IDLE;
          tx_active_q <= 1'b0;
          tx_q        <= !brk;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            tx_q <= !brk;
            if (hold_full_q && !brk) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              state_q     <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            state_q     <= ST_FRAME;
            cnt_q       <= 8'd0;
            tx_q        <= 1'b0;
            tx_active_q <= 1'b1;
          end
          ST_FRAME: begin
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_GAP;
              gap_q   <= GAP_LAST;
              tx_q    <= 1'b1;
              if (GAP_LAST == 8'd0)
                send_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
              tx_q  <= bit_val(cnt_d[7:4], shift_q);
              if (!HAS_GAP && (cnt_d == CNT_LAST))
                send_done_q <= 1'b1;
            end
          end
          ST_GAP: begin
            gap_q <= gap_q - 8'd1;
            if (gap_q == 8'd1)
              send_done_q <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign send_if.send_ready = ~hold_full_q;
  assign tx                 = tx_q;
  assign tx_active          = tx_active_q;
  assign send_done          = send_done_q;

endmodule
